fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage that consumes the 32-bit PC-select 2:1 mux output and produces that mux's sequential input. Holds the program counter, drives pc_plus4 into the mux data0 leg (branch target is on data1, select = redirect), fetches from instruction memory over a valid/ready handshake, and presents one instruction plus PC to decode through a single-entry output buffer. Redirects flush in-flight work and discard stale responses.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- next_pc  in  32  PC-select mux output; equals pc_plus4 when redirect=0, branch target when redirect=1
- redirect  in  1  single-cycle branch/jump taken strobe (same net as mux select)
- pc_plus4  out  32  pc + 4, to mux data0
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch address (= pc)
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  instruction word returned, ≥1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- if_valid  out  1  instruction available to decode
- if_instr  out  32  fetched instruction
- if_pc  out  32  address of if_instr
- id_ready  in  1  decode accepts instruction

## Operation
- States: S_IDLE (reset), S_REQ, S_WAIT, S_DISCARD. At most one outstanding request.
- S_IDLE -> S_REQ unconditionally on first edge after rst_n release.
- S_REQ: imem_req_valid = !if_valid (registered signals only, no combinational path from id_ready/imem inputs). On accept: req_pc <= pc, pc <= {next_pc[31:2],2'b00}, -> S_WAIT.
- S_WAIT: on imem_rsp_valid: if_instr <= imem_rsp_data, if_pc <= req_pc, if_valid <= 1, -> S_REQ.
- Output buffer: if_valid clears on if_valid && id_ready; outputs hold stable while if_valid && !id_ready.
- Redirect (highest priority, every state): pc <= {next_pc[31:2],2'b00}; if_valid <= 0 (simultaneous id_ready handshake is void; decode squashes).
  - S_REQ, request not accepted this cycle -> stay S_REQ (next request uses new pc).
  - S_REQ, request accepted same cycle -> S_DISCARD.
  - S_WAIT without rsp -> S_DISCARD; S_WAIT with rsp same cycle -> response dropped, -> S_REQ.
  - S_DISCARD -> stay S_DISCARD (pc updated again).
- S_DISCARD: imem_req_valid = 0; on imem_rsp_valid drop data, -> S_REQ.
- Arithmetic: pc_plus4 = pc + 32'd4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). next_pc[1:0] ignored.

## Timing
- Reset values: pc = RESET_PC, state = S_IDLE, if_valid = 0, if_instr = 0, if_pc = 0, req_pc = 0, imem_req_valid = 0, pc_plus4 = RESET_PC + 4.
- First imem_req_valid: second cycle after rst_n release.
- Latency request-accept to if_valid: memory latency + 1 cycle. Steady state with 1-cycle memory and id_ready = 1: one instruction per 3 cycles.
- Reset mid-operation: immediate return to reset values; a response arriving after reset release while in S_IDLE/S_REQ is ignored.

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_fetched (32, increments on each if_valid && id_ready not coincident with redirect) and perf_flushes (32, increments on each redirect); both reset to 0, wrap at 2^32.
- Undefined: counters and their ports absent; behaviour otherwise identical.

## Structure
- Shared package: state enum (S_IDLE, S_REQ, S_WAIT, S_DISCARD), XLEN = 32, PC_STEP = 4.
- One sub-module natural: fetch_out_buf (single-entry valid/ready holding register with flush input). PC register and FSM stay in fetch_stage.

## Test plan
- Reset release, RESET_PC=0, memory ready always, 1-cycle latency returning addr^32'hA5A5_0000, id_ready=1 -> if_pc 0,4,8 with matching if_instr, one every 3 cycles.
- id_ready=0 for 5 cycles while if_valid -> if_instr/if_pc stable, imem_req_valid=0, no pc change.
- redirect in S_WAIT, next_pc=32'h0000_0100 -> stale response dropped, if_valid stays 0, next request addr 32'h100, next if_pc 32'h100.
- redirect coincident with request acceptance and with a separate rsp_valid in S_WAIT -> both stale words never reach if_valid; pc = target.
- pc = 32'hFFFF_FFFC -> pc_plus4 = 0, next fetch addr 0.
- rst_n asserted while S_WAIT -> all outputs to reset values immediately; fetch restarts at RESET_PC; with FETCH_PERF_EN counters read 0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DISCARD
  } fetch_state_e;
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: imem request/response channel plus the decode handoff.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );
endinterface

// File: rtl/fetch_out_buf.sv
// Single-entry valid/ready holding register between fetch and decode; flush wins over load.
module fetch_out_buf
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_flush,
  input  logic            i_ready,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc
);
  logic            r_valid;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, one-outstanding imem FSM, redirect flush.
// Optional FETCH_PERF_EN adds perf_fetched / perf_flushes counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] next_pc,
  input  logic            redirect,
  output logic [XLEN-1:0] pc_plus4,
  fetch_stage_if.master   bus
`ifdef FETCH_PERF_EN
  ,
  output logic [XLEN-1:0] perf_fetched,
  output logic [XLEN-1:0] perf_flushes
`endif
);
  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;

  logic            w_if_valid;
  logic [XLEN-1:0] w_if_instr;
  logic [XLEN-1:0] w_if_pc;
  logic [XLEN-1:0] w_next_pc;
  logic            w_req_valid;
  logic            w_accept;
  logic            w_load;

  assign w_next_pc   = {next_pc[XLEN-1:2], 2'b00};
  // Request gated only by registered state so decode/imem never loop back combinationally.
  assign w_req_valid = (r_state == S_REQ) && !w_if_valid;
  assign w_accept    = w_req_valid && bus.imem_req_ready;
  assign w_load      = (r_state == S_WAIT) && bus.imem_rsp_valid && !redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect) r_pc <= w_next_pc;
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (w_accept) begin
            r_req_pc <= r_pc;
            r_pc     <= w_next_pc;
            r_state  <= redirect ? S_DISCARD : S_WAIT;
          end else if (redirect) begin
            r_pc <= w_next_pc;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            r_pc    <= w_next_pc;
            r_state <= bus.imem_rsp_valid ? S_REQ : S_DISCARD;
          end else if (bus.imem_rsp_valid) begin
            r_state <= S_REQ;
          end
        end
        S_DISCARD: begin
          if (redirect) r_pc <= w_next_pc;
          // The stale response is the only one outstanding, so leave on it even during a redirect.
          if (bus.imem_rsp_valid) r_state <= S_REQ;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  fetch_out_buf u_out_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_flush (redirect),
    .i_ready (bus.id_ready),
    .i_instr (bus.imem_rsp_data),
    .i_pc    (r_req_pc),
    .o_valid (w_if_valid),
    .o_instr (w_if_instr),
    .o_pc    (w_if_pc)
  );

  assign pc_plus4           = r_pc + PC_STEP;
  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.if_valid       = w_if_valid;
  assign bus.if_instr       = w_if_instr;
  assign bus.if_pc          = w_if_pc;

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] r_perf_fetched;
  logic [XLEN-1:0] r_perf_flushes;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_flushes <= '0;
    end else begin
      if (w_if_valid && bus.id_ready && !redirect) r_perf_fetched <= r_perf_fetched + 1'b1;
      if (redirect)                                r_perf_flushes <= r_perf_flushes + 1'b1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushes = r_perf_flushes;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: throughput, stall, redirects, PC wrap, mid-run reset.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] target = '0;
  logic [31:0] next_pc;
  logic [31:0] pc_plus4;
  logic        lat2 = 1'b0;
  logic        p1;
  logic [31:0] d1;
  int          n_run = 0;
  int          n_fail = 0;
  int          n;

  fetch_stage_if bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushes;
`endif

  always #5 clk = ~clk;

  // PC-select mux in front of the stage
  assign next_pc = redirect ? target : pc_plus4;

  fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .next_pc  (next_pc),
    .redirect (redirect),
    .pc_plus4 (pc_plus4),
    .bus      (bus.master)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushes (perf_flushes)
`endif
  );

  // Instruction memory: always ready, 1- or 2-cycle latency, data = addr ^ K
  assign bus.imem_req_ready = 1'b1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1                 <= 1'b0;
      d1                 <= '0;
      bus.imem_rsp_valid <= 1'b0;
      bus.imem_rsp_data  <= '0;
    end else begin
      p1                 <= bus.imem_req_valid && bus.imem_req_ready;
      d1                 <= bus.imem_req_addr ^ K;
      bus.imem_rsp_valid <= lat2 ? p1 : (bus.imem_req_valid && bus.imem_req_ready);
      bus.imem_rsp_data  <= lat2 ? d1 : (bus.imem_req_addr ^ K);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin step(); cyc++; end while (!bus.if_valid && cyc < 40);
    if (!bus.if_valid) chk("valid_timeout", 32'(bus.if_valid), 32'd1);
  endtask

  task automatic wait_req();
    int c = 0;
    do begin step(); c++; end while (!bus.imem_req_valid && c < 40);
    if (!bus.imem_req_valid) chk("req_timeout", 32'(bus.imem_req_valid), 32'd1);
  endtask

  initial begin
    bus.id_ready = 1'b1;
    repeat (3) step();
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'd4);
    chk("rst_if_instr", bus.if_instr, 32'd0);
    chk("rst_if_pc", bus.if_pc, 32'd0);

    // Throughput: one instruction every 3 cycles
    rst_n = 1'b1;
    chk("idle_req_valid", 32'(bus.imem_req_valid), 32'd0);
    step();
    chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("first_req_addr", bus.imem_req_addr, 32'd0);
    for (int i = 0; i < 3; i++) begin
      wait_valid(n);
      chk("seq_pc", bus.if_pc, 32'(4 * i));
      chk("seq_instr", bus.if_instr, 32'(4 * i) ^ K);
      if (i > 0) chk("seq_interval", 32'(n), 32'd3);
    end
    step();

    // Decode stall: outputs hold, no request, pc frozen
    bus.id_ready = 1'b0;
    wait_valid(n);
    chk("stall_pc0", bus.if_pc, 32'd12);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", 32'(bus.if_valid), 32'd1);
      chk("stall_pc", bus.if_pc, 32'd12);
      chk("stall_instr", bus.if_instr, 32'd12 ^ K);
      chk("stall_req", 32'(bus.imem_req_valid), 32'd0);
      chk("stall_pc4", pc_plus4, 32'd20);
    end
    bus.id_ready = 1'b1;
    step();
    chk("unstall_valid", 32'(bus.if_valid), 32'd0);
    chk("unstall_addr", bus.imem_req_addr, 32'd16);

    // Redirect in S_WAIT before the (2-cycle) response
    lat2 = 1'b1;
    step();
    redirect = 1'b1; target = 32'h0000_0100;
    step();
    redirect = 1'b0;
    chk("rdw_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rdw_pc4", pc_plus4, 32'h104);
    wait_req();
    chk("rdw_addr", bus.imem_req_addr, 32'h100);
    wait_valid(n);
    chk("rdw_if_pc", bus.if_pc, 32'h100);
    chk("rdw_if_instr", bus.if_instr, 32'h100 ^ K);

    // Redirect coincident with acceptance, then with a response in S_WAIT
    lat2 = 1'b0;
    wait_req();
    redirect = 1'b1; target = 32'h0000_0200;
    step();
    redirect = 1'b0;
    chk("rda_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rda_pc4", pc_plus4, 32'h204);
    wait_req();
    chk("rda_addr", bus.imem_req_addr, 32'h200);
    step();
    redirect = 1'b1; target = 32'h0000_0300;
    step();
    redirect = 1'b0;
    chk("rdr_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rdr_addr", bus.imem_req_addr, 32'h300);
    wait_valid(n);
    chk("rdr_if_pc", bus.if_pc, 32'h300);
    chk("rdr_if_instr", bus.if_instr, 32'h300 ^ K);

    // Redirect voids the handshake and jumps to the top of memory
    redirect = 1'b1; target = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    chk("wrap_if_valid", 32'(bus.if_valid), 32'd0);
    chk("wrap_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4, 32'h0);
    wait_valid(n);
    chk("wrap_if_pc", bus.if_pc, 32'hFFFF_FFFC);
    chk("wrap_if_instr", bus.if_instr, 32'h5A5A_FFFC);
    wait_req();
    chk("wrap_next_addr", bus.imem_req_addr, 32'h0);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 32'd6);
    chk("perf_flushes", perf_flushes, 32'd4);
`endif

    // Reset while waiting on a response
    step();
    rst_n = 1'b0;
    #1;
    chk("mrst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("mrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("mrst_pc4", pc_plus4, 32'd4);
    chk("mrst_if_pc", bus.if_pc, 32'd0);
    chk("mrst_if_instr", bus.if_instr, 32'd0);
`ifdef FETCH_PERF_EN
    chk("mrst_perf_fetched", perf_fetched, 32'd0);
    chk("mrst_perf_flushes", perf_flushes, 32'd0);
`endif
    step(); step();
    rst_n = 1'b1;
    wait_valid(n);
    chk("restart_if_pc", bus.if_pc, 32'd0);
    chk("restart_if_instr", bus.if_instr, K);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
